// File: rtl/conv_sched_pkg.sv
// Shared types and helpers for the conv layer pass scheduler.
// Holds the state encoding and the per-layer tile count lookup.
package conv_sched_pkg;

  localparam int TILES_PER_BATCH_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAM_REQ,
    S_ISSUE,
    S_RUN,
    S_CHANGE,
    S_SETTLE,
    S_FINISH
  } state_e;

  // Tiles per VGG16 conv layer; 0 flags an unsupported layer number.
  function automatic logic [8:0] tiles_per_layer(input logic [2:0] l);
    logic [8:0] t;
    case (l)
      3'd1:    t = 9'd256;
      3'd2:    t = 9'd64;
      3'd3:    t = 9'd16;
      3'd4:    t = 9'd4;
      3'd5:    t = 9'd1;
      default: t = 9'd0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/conv_loop_counter.sv
// Nested channel/kernel/tile loop counters for one conv layer.
// Flags report which loop level wraps on the current pass.
module conv_loop_counter
  import conv_sched_pkg::*;
#(
  parameter int TPB   = TILES_PER_BATCH_DEF,
  parameter int GRP_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             adv_i,
  input  logic [GRP_W-1:0] n_ch_i,
  input  logic [GRP_W-1:0] n_ker_i,
  input  logic [8:0]       n_tiles_i,
  output logic [GRP_W-1:0] ch_o,
  output logic [GRP_W-1:0] ker_o,
  output logic [7:0]       tile_o,
  output logic [7:0]       base_o,
  output logic             ch_last_o,
  output logic             ker_last_o,
  output logic             batch_last_o,
  output logic             layer_last_o
);

  localparam logic [9:0] TPB_W = 10'(TPB);

  logic [GRP_W-1:0] ch_q, ch_d, ker_q, ker_d;
  logic [7:0]       tile_q, tile_d, base_q, base_d;
  logic [9:0]       tile_nx, batch_end;

  assign tile_nx   = {2'b00, tile_q} + 10'd1;
  assign batch_end = {2'b00, base_q} + TPB_W;

  assign ch_last_o    = ch_q == n_ch_i - GRP_W'(1);
  assign ker_last_o   = ker_q == n_ker_i - GRP_W'(1);
  assign layer_last_o = tile_nx == {1'b0, n_tiles_i};
  assign batch_last_o = (tile_nx == batch_end) || layer_last_o;

  assign ch_o   = ch_q;
  assign ker_o  = ker_q;
  assign tile_o = tile_q;
  assign base_o = base_q;

  // Innermost loop first; the last pass of the layer leaves counters parked.
  always_comb begin
    ch_d   = ch_q;
    ker_d  = ker_q;
    tile_d = tile_q;
    base_d = base_q;
    if (clr_i) begin
      ch_d   = '0;
      ker_d  = '0;
      tile_d = '0;
      base_d = '0;
    end else if (adv_i) begin
      if (!ch_last_o) begin
        ch_d = ch_q + GRP_W'(1);
      end else if (!ker_last_o) begin
        ch_d  = '0;
        ker_d = ker_q + GRP_W'(1);
      end else if (!batch_last_o) begin
        ch_d   = '0;
        ker_d  = '0;
        tile_d = tile_nx[7:0];
      end else if (!layer_last_o) begin
        ch_d   = '0;
        ker_d  = '0;
        tile_d = tile_nx[7:0];
        base_d = tile_nx[7:0];
      end
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q   <= '0;
      ker_q  <= '0;
      tile_q <= '0;
      base_q <= '0;
    end else begin
      ch_q   <= ch_d;
      ker_q  <= ker_d;
      tile_q <= tile_d;
      base_q <= base_d;
    end
  end

endmodule

// File: rtl/conv_pass_scheduler.sv
// Loop sequencer for one VGG16 conv layer: tiles, kernel and channel
// groups, activation controller handshakes and DRAM batch refills.
module conv_pass_scheduler
  import conv_sched_pkg::*;
#(
  parameter int TILES_PER_BATCH = TILES_PER_BATCH_DEF,
  parameter int GRP_W           = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       conv_layer_num,
  input  logic [GRP_W-1:0] num_ch_groups,
  input  logic [GRP_W-1:0] num_ker_groups,
  input  logic             sliding_finish,
  input  logic             dram_ack,
  output logic [7:0]       tile_idx,
  output logic             start_activation_load,
  output logic             ker_change,
  output logic             tile_change,
  output logic             dram_access,
  output logic             dram_req,
  output logic [7:0]       dram_tile_base,
  output logic [GRP_W-1:0] ch_group_idx,
  output logic [GRP_W-1:0] ker_group_idx,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  state_e           state_q;
  logic [GRP_W-1:0] nch_q, nker_q;
  logic [8:0]       ntiles_q, cfg_tiles;
  logic             cfg_ok, clr, adv;
  logic             ch_last, ker_last, batch_last, layer_last;
  logic [7:0]       base;
  logic             busy_q, done_q, err_q, sal_q;
  logic             kc_q, tc_q, da_q, req_q;
  logic [7:0]       rbase_q;
  logic             pend_dram_q, pend_fin_q;

  assign cfg_tiles = tiles_per_layer(conv_layer_num);
  assign cfg_ok    = cfg_tiles != 9'd0;
  assign clr       = (state_q == S_IDLE) && start && cfg_ok;
  assign adv       = (state_q == S_RUN) && sliding_finish;

  conv_loop_counter #(
    .TPB   (TILES_PER_BATCH),
    .GRP_W (GRP_W)
  ) u_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (clr),
    .adv_i        (adv),
    .n_ch_i       (nch_q),
    .n_ker_i      (nker_q),
    .n_tiles_i    (ntiles_q),
    .ch_o         (ch_group_idx),
    .ker_o        (ker_group_idx),
    .tile_o       (tile_idx),
    .base_o       (base),
    .ch_last_o    (ch_last),
    .ker_last_o   (ker_last),
    .batch_last_o (batch_last),
    .layer_last_o (layer_last)
  );

  // Sequencer FSM; every handshake output is a registered pulse or level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      nch_q       <= '0;
      nker_q      <= '0;
      ntiles_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      sal_q       <= 1'b0;
      kc_q        <= 1'b0;
      tc_q        <= 1'b0;
      da_q        <= 1'b0;
      req_q       <= 1'b0;
      rbase_q     <= '0;
      pend_dram_q <= 1'b0;
      pend_fin_q  <= 1'b0;
    end else begin
      sal_q  <= 1'b0;
      kc_q   <= 1'b0;
      tc_q   <= 1'b0;
      da_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            err_q <= !cfg_ok;
            if (cfg_ok) begin
              nch_q    <= (num_ch_groups == '0) ? GRP_W'(1) : num_ch_groups;
              nker_q   <= (num_ker_groups == '0) ? GRP_W'(1) : num_ker_groups;
              ntiles_q <= cfg_tiles;
              busy_q   <= 1'b1;
              req_q    <= 1'b1;
              rbase_q  <= '0;
              state_q  <= S_DRAM_REQ;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_FINISH;
            end
          end
        end
        S_DRAM_REQ: begin
          if (dram_ack) begin
            req_q   <= 1'b0;
            sal_q   <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: state_q <= S_RUN;
        S_RUN: begin
          if (sliding_finish && ch_last) begin
            state_q     <= S_CHANGE;
            kc_q        <= !ker_last;
            tc_q        <= ker_last && !batch_last;
            da_q        <= ker_last && batch_last;
            pend_dram_q <= ker_last && batch_last;
            pend_fin_q  <= ker_last && layer_last;
          end
        end
        S_CHANGE: state_q <= S_SETTLE;
        S_SETTLE: begin
          if (pend_fin_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_FINISH;
          end else if (pend_dram_q) begin
            req_q   <= 1'b1;
            rbase_q <= base;
            state_q <= S_DRAM_REQ;
          end else begin
            sal_q   <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_FINISH: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign start_activation_load = sal_q;
  assign ker_change            = kc_q;
  assign tile_change           = tc_q;
  assign dram_access           = da_q;
  assign dram_req              = req_q;
  assign dram_tile_base        = rbase_q;
  assign busy                  = busy_q;
  assign done                  = done_q;
  assign cfg_err               = err_q;

endmodule

// File: tb/tb_conv_pass_scheduler.sv
// Bench for conv_pass_scheduler: the bench plays the activation
// controller and DMA and predicts every pass from nested loop order.
module tb_conv_pass_scheduler;

  localparam int TPB = 4;
  localparam int GW  = 10;

  logic          clk = 1'b0;
  logic          rst_n, start, sliding_finish, dram_ack;
  logic [2:0]    conv_layer_num;
  logic [GW-1:0] num_ch_groups, num_ker_groups;
  logic [7:0]    tile_idx, dram_tile_base;
  logic          start_activation_load, ker_change, tile_change;
  logic          dram_access, dram_req, busy, done, cfg_err;
  logic [GW-1:0] ch_group_idx, ker_group_idx;

  int compared   = 0;
  int mismatched = 0;
  int cnt_kc = 0, cnt_tc = 0, cnt_da = 0;
  int cnt_req = 0, cnt_sal = 0, cnt_done = 0;
  logic req_prev = 1'b0;

  conv_pass_scheduler #(
    .TILES_PER_BATCH (TPB),
    .GRP_W           (GW)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .start                 (start),
    .conv_layer_num        (conv_layer_num),
    .num_ch_groups         (num_ch_groups),
    .num_ker_groups        (num_ker_groups),
    .sliding_finish        (sliding_finish),
    .dram_ack              (dram_ack),
    .tile_idx              (tile_idx),
    .start_activation_load (start_activation_load),
    .ker_change            (ker_change),
    .tile_change           (tile_change),
    .dram_access           (dram_access),
    .dram_req              (dram_req),
    .dram_tile_base        (dram_tile_base),
    .ch_group_idx          (ch_group_idx),
    .ker_group_idx         (ker_group_idx),
    .busy                  (busy),
    .done                  (done),
    .cfg_err               (cfg_err)
  );

  always #5 clk = ~clk;

  // Pulse and request-edge tallies.
  always @(negedge clk) begin
    if (rst_n) begin
      cnt_kc   += int'(ker_change);
      cnt_tc   += int'(tile_change);
      cnt_da   += int'(dram_access);
      cnt_sal  += int'(start_activation_load);
      cnt_done += int'(done);
      cnt_req  += int'(dram_req && !req_prev);
    end
    req_prev = dram_req;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic run_layer(input int L, input int nch, input int nker,
                           input int ack_dly, input bit poke);
    int T, nc, nk, nb, bend, waited;
    int s_kc, s_tc, s_da, s_req, s_sal, s_done;
    int et, ek, ec;
    bit abort, ekc, etc, eda;
    T  = 256 >> (2 * (L - 1));
    nc = (nch == 0) ? 1 : nch;
    nk = (nker == 0) ? 1 : nker;
    nb = (T + TPB - 1) / TPB;
    s_kc = cnt_kc; s_tc = cnt_tc; s_da = cnt_da;
    s_req = cnt_req; s_sal = cnt_sal; s_done = cnt_done;
    conv_layer_num = 3'(L);
    num_ch_groups  = GW'(nch);
    num_ker_groups = GW'(nker);
    start = 1'b1;
    tick;
    start = 1'b0;
    compared++;
    if (busy !== 1'b1 || cfg_err !== 1'b0) begin
      mismatched++;
      $display("FAIL start L%0d: busy=%b cfg_err=%b want 1/0", L, busy, cfg_err);
    end
    abort = 1'b0;
    for (int b = 0; b < T && !abort; b += TPB) begin
      bend = (b + TPB < T) ? b + TPB : T;
      waited = 0;
      while (dram_req !== 1'b1 && waited < 200) begin
        tick;
        waited++;
      end
      compared++;
      if (dram_req !== 1'b1 || waited != 0) begin
        mismatched++;
        $display("FAIL dram_req L%0d base %0d: req=%b after %0d cyc want 1 at 0",
                 L, b, dram_req, waited);
        if (dram_req !== 1'b1) abort = 1'b1;
      end
      if (!abort) begin
        compared++;
        if (dram_tile_base !== 8'(b)) begin
          mismatched++;
          $display("FAIL dram_tile_base: got %0d want %0d", dram_tile_base, b);
        end
        for (int d = 0; d < ack_dly; d++) begin
          if (poke && d == 5) begin
            conv_layer_num = 3'd5;
            start = 1'b1;
          end
          tick;
          start = 1'b0;
          conv_layer_num = 3'(L);
          compared++;
          if (dram_req !== 1'b1 || start_activation_load !== 1'b0) begin
            mismatched++;
            $display("FAIL ack_wait d%0d: req=%b sal=%b want 1/0",
                     d, dram_req, start_activation_load);
          end
        end
        dram_ack = 1'b1;
        tick;
        dram_ack = 1'b0;
        compared++;
        if (dram_req !== 1'b0 || start_activation_load !== 1'b1) begin
          mismatched++;
          $display("FAIL ack_issue: req=%b sal=%b want 0/1",
                   dram_req, start_activation_load);
        end
      end
      for (int t = b; t < bend && !abort; t++) begin
        for (int k = 0; k < nk && !abort; k++) begin
          if (!(t == b && k == 0)) begin
            compared++;
            if (start_activation_load !== 1'b1) begin
              mismatched++;
              $display("FAIL sal_latency t%0d k%0d: sal=%b want 1", t, k,
                       start_activation_load);
            end
          end
          compared++;
          if (tile_idx !== 8'(t) || ker_group_idx !== GW'(k) ||
              ch_group_idx !== GW'(0)) begin
            mismatched++;
            $display("FAIL pass_idx: got t%0d k%0d c%0d want t%0d k%0d c0",
                     tile_idx, ker_group_idx, ch_group_idx, t, k);
          end
          for (int c = 0; c < nc; c++) begin
            tick;
            if (c == 0) begin
              compared++;
              if (start_activation_load !== 1'b0) begin
                mismatched++;
                $display("FAIL sal_width: sal=%b want 0", start_activation_load);
              end
            end
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
              dram_ack = 1'($urandom_range(0, 1));
              tick;
            end
            dram_ack = 1'b0;
            sliding_finish = 1'b1;
            tick;
            sliding_finish = 1'b0;
            if (c < nc - 1) begin
              compared++;
              if (ker_change !== 1'b0 || tile_change !== 1'b0 ||
                  dram_access !== 1'b0 || ch_group_idx !== GW'(c + 1) ||
                  ker_group_idx !== GW'(k) || tile_idx !== 8'(t)) begin
                mismatched++;
                $display("FAIL ch_step: kc%b tc%b da%b c%0d want c%0d no pulse",
                         ker_change, tile_change, dram_access, ch_group_idx, c + 1);
              end
            end else begin
              ekc = (k < nk - 1);
              etc = !ekc && (t < bend - 1);
              eda = !ekc && !etc;
              if (ekc) begin
                et = t; ek = k + 1; ec = 0;
              end else if (t < T - 1) begin
                et = t + 1; ek = 0; ec = 0;
              end else begin
                et = t; ek = k; ec = c;
              end
              compared++;
              if (ker_change !== ekc || tile_change !== etc || dram_access !== eda) begin
                mismatched++;
                $display("FAIL pulse t%0d k%0d: kc%b tc%b da%b want kc%b tc%b da%b",
                         t, k, ker_change, tile_change, dram_access, ekc, etc, eda);
              end
              compared++;
              if (tile_idx !== 8'(et) || ker_group_idx !== GW'(ek) ||
                  ch_group_idx !== GW'(ec)) begin
                mismatched++;
                $display("FAIL next_idx: got t%0d k%0d c%0d want t%0d k%0d c%0d",
                         tile_idx, ker_group_idx, ch_group_idx, et, ek, ec);
              end
              sliding_finish = 1'($urandom_range(0, 1));
              tick;
              sliding_finish = 1'b0;
              tick;
            end
          end
        end
      end
    end
    if (!abort) begin
      compared++;
      if (done !== 1'b1 || busy !== 1'b0) begin
        mismatched++;
        $display("FAIL done_pulse L%0d: done=%b busy=%b want 1/0", L, done, busy);
      end
      tick;
      compared++;
      if (done !== 1'b0 || tile_idx !== 8'(T - 1) ||
          ker_group_idx !== GW'(nk - 1) || ch_group_idx !== GW'(nc - 1)) begin
        mismatched++;
        $display("FAIL final_hold: done=%b t%0d k%0d c%0d want 0 t%0d k%0d c%0d",
                 done, tile_idx, ker_group_idx, ch_group_idx, T - 1, nk - 1, nc - 1);
      end
      compared++;
      if (cnt_kc - s_kc != T * (nk - 1) || cnt_tc - s_tc != T - nb ||
          cnt_da - s_da != nb || cnt_req - s_req != nb ||
          cnt_sal - s_sal != T * nk || cnt_done - s_done != 1) begin
        mismatched++;
        $display("FAIL counts L%0d: kc%0d tc%0d da%0d req%0d sal%0d done%0d want %0d %0d %0d %0d %0d 1",
                 L, cnt_kc - s_kc, cnt_tc - s_tc, cnt_da - s_da, cnt_req - s_req,
                 cnt_sal - s_sal, cnt_done - s_done, T * (nk - 1), T - nb, nb, nb, T * nk);
      end
    end else begin
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      tick;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    sliding_finish = 1'b0;
    dram_ack = 1'b0;
    conv_layer_num = 3'd0;
    num_ch_groups = '0;
    num_ker_groups = '0;
    tick;
    tick;
    compared++;
    if ({tile_idx, dram_tile_base, ch_group_idx, ker_group_idx} !== '0 ||
        {start_activation_load, ker_change, tile_change, dram_access,
         dram_req, busy, done, cfg_err} !== 8'h00) begin
      mismatched++;
      $display("FAIL reset_state: some output nonzero under reset");
    end
    rst_n = 1'b1;
    tick;
    tick;
    compared++;
    if (busy !== 1'b0 || dram_req !== 1'b0 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL idle_after_reset: busy=%b req=%b done=%b want 0", busy, dram_req, done);
    end
  endtask

  task automatic test_bad_cfg;
    logic [2:0] bad [3];
    bad[0] = 3'd0; bad[1] = 3'd6; bad[2] = 3'd7;
    foreach (bad[i]) begin
      conv_layer_num = bad[i];
      start = 1'b1;
      tick;
      start = 1'b0;
      compared++;
      if (cfg_err !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || dram_req !== 1'b0) begin
        mismatched++;
        $display("FAIL bad_cfg L%0d: err=%b done=%b busy=%b req=%b want 1 1 0 0",
                 bad[i], cfg_err, done, busy, dram_req);
      end
      tick;
      compared++;
      if (cfg_err !== 1'b1 || done !== 1'b0 || dram_req !== 1'b0) begin
        mismatched++;
        $display("FAIL bad_cfg_after L%0d: err=%b done=%b req=%b want 1 0 0",
                 bad[i], cfg_err, done, dram_req);
      end
      tick;
    end
  endtask

  task automatic test_directed;
    run_layer(5, 2, 1, 0, 1'b0);
    run_layer(4, 1, 2, 1, 1'b0);
    run_layer(3, 1, 1, 2, 1'b0);
    run_layer(1, 0, 0, 0, 1'b0);
  endtask

  task automatic test_ack_delay;
    run_layer(3, 1, 2, 20, 1'b1);
  endtask

  task automatic test_random;
    for (int r = 0; r < 5; r++) begin
      run_layer($urandom_range(2, 5), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end
  endtask

  task automatic test_reset_midrun;
    int waited;
    conv_layer_num = 3'd3;
    num_ch_groups = GW'(2);
    num_ker_groups = GW'(2);
    start = 1'b1;
    tick;
    start = 1'b0;
    waited = 0;
    while (dram_req !== 1'b1 && waited < 50) begin
      tick;
      waited++;
    end
    dram_ack = 1'b1;
    tick;
    dram_ack = 1'b0;
    tick;
    sliding_finish = 1'b1;
    tick;
    sliding_finish = 1'b0;
    tick;
    compared++;
    if (busy !== 1'b1 || ch_group_idx !== GW'(1)) begin
      mismatched++;
      $display("FAIL midrun_setup: busy=%b ch=%0d want 1 1", busy, ch_group_idx);
    end
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if ({tile_idx, dram_tile_base, ch_group_idx, ker_group_idx} !== '0 ||
        {start_activation_load, ker_change, tile_change, dram_access,
         dram_req, busy, done, cfg_err} !== 8'h00) begin
      mismatched++;
      $display("FAIL midrun_reset: outputs nonzero busy=%b ch=%0d", busy, ch_group_idx);
    end
    tick;
    rst_n = 1'b1;
    tick;
    tick;
    compared++;
    if (busy !== 1'b0 || dram_req !== 1'b0 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL after_midrun_reset: busy=%b req=%b done=%b want 0", busy, dram_req, done);
    end
  endtask

  initial begin
    test_reset;
    test_bad_cfg;
    test_directed;
    test_ack_delay;
    test_random;
    test_reset_midrun;
    test_directed;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
